// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and latency defaults for the multiply write-back scheduler
package mips_pkg;

    localparam int REG_ADDR_W      = 5;
    localparam int MULT_WB_LAT_DEF = 5;
    localparam int ALU_WB_LAT_DEF  = 3;

    typedef struct packed {
        logic                  valid;
        logic                  is_mult;
        logic [REG_ADDR_W-1:0] dest;
    } wb_slot_t;

    function automatic wb_slot_t make_slot(input logic is_mult, input logic [REG_ADDR_W-1:0] dest);
        wb_slot_t s;
        s.valid   = 1'b1;
        s.is_mult = is_mult;
        s.dest    = dest;
        return s;
    endfunction

endpackage

// File: rtl/mips_wb_slot_table.sv
// rtl/mips_wb_slot_table.sv - write-port reservation shift register with top and mid insert
module mips_wb_slot_table
    import mips_pkg::*;
#(
    parameter int DEPTH = 5,
    parameter int MID   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  top_wr,
    input  wb_slot_t              top_entry,
    input  logic                  mid_wr,
    input  wb_slot_t              mid_entry,
    output wb_slot_t [DEPTH-1:0]  slots
);

    wb_slot_t [DEPTH-1:0] slots_q;
    wb_slot_t [DEPTH-1:0] slots_d;

    // Register k holds what writes k cycles from now; the insert lands one slot below the
    // logical reservation slot because the shift happens on the same edge.
    always_comb begin
        slots_d = '0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            slots_d[k] = slots_q[k+1];
        end
        slots_d[DEPTH-1] = top_wr ? top_entry : '0;
        if (mid_wr) begin
            slots_d[MID] = mid_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slots_q <= '0;
        end else begin
            slots_q <= slots_d;
        end
    end

    assign slots = slots_q;

endmodule

// File: rtl/mips_mult_wb_scheduler.sv
// rtl/mips_mult_wb_scheduler.sv - issue-time hazard check and write-port ownership for the multiplier
module mips_mult_wb_scheduler
    import mips_pkg::*;
#(
    parameter int MULT_WB_LAT = MULT_WB_LAT_DEF,
    parameter int ALU_WB_LAT  = ALU_WB_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid_D,
    input  logic                  mult_start_D,
    input  logic                  reg_write_D,
    input  logic [REG_ADDR_W-1:0] dest_D,
    input  logic [REG_ADDR_W-1:0] src_a_D,
    input  logic [REG_ADDR_W-1:0] src_b_D,
    input  logic                  flush_D,
    output logic                  stall_D,
    output logic                  wb_valid_W,
    output logic                  wb_is_mult_W,
    output logic [REG_ADDR_W-1:0] wb_dest_W,
    output logic [2:0]            mult_inflight,
    output logic                  hazard_raw,
    output logic                  hazard_waw,
    output logic                  hazard_port
);

    wb_slot_t [MULT_WB_LAT-1:0] slots;

    logic       mult_cand;
    logic       alu_cand;
    logic       raw_hit;
    logic       waw_hit;
    logic       port_hit;
    logic       stall;
    logic       mult_issue;
    logic       alu_issue;
    logic       mult_retire;
    logic [2:0] inflight_d;
    logic [2:0] inflight_q;

    assign mult_cand = mult_start_D & (dest_D != '0);
    assign alu_cand  = ~mult_start_D & reg_write_D & (dest_D != '0);

    // The logical top slot is always empty in the registers, so scanning 1..LAT-1 covers
    // every in-flight multiply except the one writing this cycle (regfile is write-first).
    always_comb begin
        raw_hit = 1'b0;
        waw_hit = 1'b0;
        for (int k = 1; k < MULT_WB_LAT; k++) begin
            if (slots[k].valid && slots[k].is_mult) begin
                if ((src_a_D != '0 && src_a_D == slots[k].dest) ||
                    (src_b_D != '0 && src_b_D == slots[k].dest)) begin
                    raw_hit = 1'b1;
                end
                if (k > ALU_WB_LAT && alu_cand && dest_D == slots[k].dest) begin
                    waw_hit = 1'b1;
                end
            end
        end
        port_hit = alu_cand & slots[ALU_WB_LAT].valid;
    end

    assign hazard_raw  = rst & issue_valid_D & raw_hit;
    assign hazard_waw  = rst & issue_valid_D & waw_hit;
    assign hazard_port = rst & issue_valid_D & port_hit;

    assign stall   = issue_valid_D & ~flush_D & (raw_hit | waw_hit | port_hit);
    assign stall_D = rst & stall;

    assign mult_issue  = issue_valid_D & ~flush_D & ~stall & mult_cand;
    assign alu_issue   = issue_valid_D & ~flush_D & ~stall & alu_cand;
    assign mult_retire = slots[0].valid & slots[0].is_mult;

    mips_wb_slot_table #(
        .DEPTH (MULT_WB_LAT),
        .MID   (ALU_WB_LAT - 1)
    ) u_slot_table (
        .clk       (clk),
        .rst       (rst),
        .top_wr    (mult_issue),
        .top_entry (make_slot(1'b1, dest_D)),
        .mid_wr    (alu_issue),
        .mid_entry (make_slot(1'b0, dest_D)),
        .slots     (slots)
    );

    always_comb begin
        inflight_d = inflight_q + {2'b00, mult_issue} - {2'b00, mult_retire};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign mult_inflight = inflight_q;
    assign wb_valid_W    = rst & slots[0].valid;
    assign wb_is_mult_W  = rst & slots[0].is_mult;
    assign wb_dest_W     = rst ? slots[0].dest : '0;

endmodule

// File: tb/tb_mips_mult_wb_scheduler.sv
// tb/tb_mips_mult_wb_scheduler.sv - directed vector bench for mips_mult_wb_scheduler
module tb_mips_mult_wb_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       issue_valid_D = 1'b0;
    logic       mult_start_D = 1'b0;
    logic       reg_write_D = 1'b0;
    logic [4:0] dest_D = '0;
    logic [4:0] src_a_D = '0;
    logic [4:0] src_b_D = '0;
    logic       flush_D = 1'b0;
    logic       stall_D;
    logic       wb_valid_W;
    logic       wb_is_mult_W;
    logic [4:0] wb_dest_W;
    logic [2:0] mult_inflight;
    logic       hazard_raw;
    logic       hazard_waw;
    logic       hazard_port;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mips_mult_wb_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid_D (issue_valid_D),
        .mult_start_D  (mult_start_D),
        .reg_write_D   (reg_write_D),
        .dest_D        (dest_D),
        .src_a_D       (src_a_D),
        .src_b_D       (src_b_D),
        .flush_D       (flush_D),
        .stall_D       (stall_D),
        .wb_valid_W    (wb_valid_W),
        .wb_is_mult_W  (wb_is_mult_W),
        .wb_dest_W     (wb_dest_W),
        .mult_inflight (mult_inflight),
        .hazard_raw    (hazard_raw),
        .hazard_waw    (hazard_waw),
        .hazard_port   (hazard_port)
    );

    typedef struct {
        logic       v, m, rw;
        logic [4:0] d, a, b;
        logic       fl;
        logic       st, wv, wm;
        logic [4:0] wd;
        logic [2:0] inf;
        logic       raw, waw, port;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic v, m, rw, input logic [4:0] d, a, b, input logic fl,
                                input logic st, wv, wm, input logic [4:0] wd, input logic [2:0] inf,
                                input logic raw, waw, port);
        vec_t x;
        x.v = v; x.m = m; x.rw = rw; x.d = d; x.a = a; x.b = b; x.fl = fl;
        x.st = st; x.wv = wv; x.wm = wm; x.wd = wd; x.inf = inf;
        x.raw = raw; x.waw = waw; x.port = port;
        vecs.push_back(x);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic v, m, rw, input logic [4:0] d, a, b, input logic fl);
        issue_valid_D = v; mult_start_D = m; reg_write_D = rw;
        dest_D = d; src_a_D = a; src_b_D = b; flush_D = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_all(input string tag, input int idx, input vec_t x);
        chk({tag, ".stall"}, idx, 32'(stall_D), 32'(x.st));
        chk({tag, ".wb_valid"}, idx, 32'(wb_valid_W), 32'(x.wv));
        chk({tag, ".wb_is_mult"}, idx, 32'(wb_is_mult_W), 32'(x.wm));
        chk({tag, ".wb_dest"}, idx, 32'(wb_dest_W), 32'(x.wd));
        chk({tag, ".inflight"}, idx, 32'(mult_inflight), 32'(x.inf));
        chk({tag, ".raw"}, idx, 32'(hazard_raw), 32'(x.raw));
        chk({tag, ".waw"}, idx, 32'(hazard_waw), 32'(x.waw));
        chk({tag, ".port"}, idx, 32'(hazard_port), 32'(x.port));
    endtask

    initial begin
        vec_t x;
        //  v m rw  d  a  b fl | st wv wm wd inf raw waw port
        add(1,1,0,  8, 0, 0,0,   0, 0, 0, 0, 0,  0,  0,  0);   // c0 mult r8
        for (int i = 0; i < 4; i++)
            add(0,0,0, 0,0,0,0,  0, 0, 0, 0, 1,  0,  0,  0);   // c1..c4
        add(0,0,0,  0, 0, 0,0,   0, 1, 1, 8, 1,  0,  0,  0);   // c5 mult writes
        add(0,0,0,  0, 0, 0,0,   0, 0, 0, 0, 0,  0,  0,  0);   // c6
        add(1,1,0,  8, 0, 0,0,   0, 0, 0, 0, 0,  0,  0,  0);   // c7 mult r8
        add(0,0,0,  0, 0, 0,0,   0, 0, 0, 0, 1,  0,  0,  0);   // c8
        add(1,0,1,  9, 0, 0,0,   1, 0, 0, 0, 1,  0,  0,  1);   // c9 add r9 port clash
        add(1,0,1,  9, 0, 0,0,   0, 0, 0, 0, 1,  0,  0,  0);   // c10 add issues
        add(0,0,0,  0, 0, 0,0,   0, 0, 0, 0, 1,  0,  0,  0);   // c11
        add(0,0,0,  0, 0, 0,0,   0, 1, 1, 8, 1,  0,  0,  0);   // c12 mult writes
        add(0,0,0,  0, 0, 0,0,   0, 1, 0, 9, 0,  0,  0,  0);   // c13 add writes
        add(1,1,0,  8, 0, 0,0,   0, 0, 0, 0, 0,  0,  0,  0);   // c14 mult r8
        add(1,0,1, 10, 8, 0,0,   1, 0, 0, 0, 1,  1,  0,  0);   // c15 raw
        add(1,0,1, 10, 8, 0,0,   1, 0, 0, 0, 1,  1,  0,  1);   // c16 raw + port
        add(1,0,1, 10, 8, 0,0,   1, 0, 0, 0, 1,  1,  0,  0);   // c17
        add(1,0,1, 10, 8, 0,0,   1, 0, 0, 0, 1,  1,  0,  0);   // c18
        add(1,0,1, 10, 8, 0,0,   0, 1, 1, 8, 1,  0,  0,  0);   // c19 write-first, issues
        add(0,0,0,  0, 0, 0,0,   0, 0, 0, 0, 0,  0,  0,  0);   // c20
        add(0,0,0,  0, 0, 0,0,   0, 0, 0, 0, 0,  0,  0,  0);   // c21
        add(0,0,0,  0, 0, 0,0,   0, 1, 0,10, 0,  0,  0,  0);   // c22 add r10 writes
        add(1,1,0,  8, 0, 0,0,   0, 0, 0, 0, 0,  0,  0,  0);   // c23 mult r8
        add(1,0,1,  8, 0, 0,0,   1, 0, 0, 0, 1,  0,  1,  0);   // c24 waw
        add(1,0,1,  8, 0, 0,0,   1, 0, 0, 0, 1,  0,  0,  1);   // c25 port
        add(1,0,1,  8, 0, 0,0,   0, 0, 0, 0, 1,  0,  0,  0);   // c26 issues
        add(0,0,0,  0, 0, 0,0,   0, 0, 0, 0, 1,  0,  0,  0);   // c27
        add(0,0,0,  0, 0, 0,0,   0, 1, 1, 8, 1,  0,  0,  0);   // c28 mult first
        add(0,0,0,  0, 0, 0,0,   0, 1, 0, 8, 0,  0,  0,  0);   // c29 add second
        for (int i = 0; i < 5; i++)
            add(1,1,0, 5'(i+1),0,0,0, 0,0,0,0, 3'(i), 0,0,0);  // c30..c34 mults r1..r5
        add(0,0,0,  0, 0, 0,0,   0, 1, 1, 1, 5,  0,  0,  0);   // c35
        add(1,0,0,  0, 0, 0,0,   0, 1, 1, 2, 4,  0,  0,  0);   // c36 zero sources
        add(1,0,0,  0, 0, 5,0,   1, 1, 1, 3, 3,  1,  0,  0);   // c37 raw on r5
        add(0,0,0,  0, 0, 0,0,   0, 1, 1, 4, 2,  0,  0,  0);   // c38
        add(0,0,0,  0, 0, 0,0,   0, 1, 1, 5, 1,  0,  0,  0);   // c39
        add(1,1,0,  0, 0, 0,0,   0, 0, 0, 0, 0,  0,  0,  0);   // c40 mult r0
        for (int i = 0; i < 5; i++)
            add(0,0,0, 0,0,0,0,  0, 0, 0, 0, 0,  0,  0,  0);   // c41..c45 r0 never writes

        drive(1, 1, 0, 8, 8, 0, 0);
        #2;
        x = '{default: '0};
        check_all("reset", 0, x);

        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            x = vecs[i];
            drive(x.v, x.m, x.rw, x.d, x.a, x.b, x.fl);
            #2;
            check_all("vec", i, x);
            @(negedge clk);
        end

        // flush beats a live hazard and leaves no reservation
        drive(1, 1, 0, 8, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 1, 9, 8, 0, 1);
        #2;
        chk("flush.stall", 1, 32'(stall_D), 0);
        chk("flush.raw", 1, 32'(hazard_raw), 1);
        @(negedge clk);
        drive(1, 1, 0, 3, 0, 0, 1);
        #2;
        chk("flush.mult_stall", 2, 32'(stall_D), 0);
        @(negedge clk);
        idle();
        #2;
        chk("flush.inflight", 3, 32'(mult_inflight), 1);
        for (int t = 4; t <= 7; t++) begin
            @(negedge clk);
            #2;
            chk("flush.wb_valid", t, 32'(wb_valid_W), (t == 5) ? 1 : 0);
            chk("flush.wb_dest", t, 32'(wb_dest_W), (t == 5) ? 8 : 0);
        end

        // asynchronous reset mid-flight drops the multiply
        @(negedge clk);
        drive(1, 1, 0, 7, 0, 0, 0);
        @(negedge clk);
        idle();
        @(negedge clk);
        drive(1, 0, 1, 9, 7, 0, 0);
        #2;
        chk("rst.pre_stall", 0, 32'(stall_D), 1);
        rst = 1'b0;
        #1;
        chk("rst.stall", 0, 32'(stall_D), 0);
        chk("rst.raw", 0, 32'(hazard_raw), 0);
        chk("rst.inflight", 0, 32'(mult_inflight), 0);
        chk("rst.wb_valid", 0, 32'(wb_valid_W), 0);
        @(negedge clk);
        idle();
        rst = 1'b1;
        for (int t = 0; t < 6; t++) begin
            #2;
            chk("rst.post_wb", t, 32'(wb_valid_W), 0);
            chk("rst.post_inflight", t, 32'(mult_inflight), 0);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
